// File: rtl/aer_pkg.sv
// AER ingress shared definitions.
// Word layout and default field widths.
package aer_pkg;

    localparam int AER_CH_W = 4;
    localparam int AER_TS_W = 20;

    typedef struct packed {
        logic [AER_CH_W-1:0] ch;
        logic [AER_TS_W-1:0] ts;
    } aer_word_t;

    function automatic aer_word_t aer_pack(
        input logic [AER_CH_W-1:0] ch,
        input logic [AER_TS_W-1:0] ts
    );
        aer_word_t w;
        w.ch = ch;
        w.ts = ts;
        return w;
    endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Head word is visible on dout without a read strobe.
module aer_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_do;
    logic             rd_do;

    // A write into a full FIFO is legal when the head leaves the same cycle.
    assign wr_do = wr_en && (!full || rd_en);
    assign rd_do = rd_en && !empty;

    assign dout  = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_do) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_do) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_do, rd_do})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/aer_ingress_pipe.sv
// AER event ingress: channel mask, FIFO, output register.
// Optional drop-and-count overflow and timestamp rollover flag.
module aer_ingress_pipe
    import aer_pkg::*;
#(
    parameter int CH_W         = AER_CH_W,
    parameter int TS_W         = AER_TS_W,
    parameter int DEPTH        = 16,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_W+TS_W-1:0]     aer_data,
    input  logic                     aer_valid,
    output logic                     aer_ready,
    input  logic [2**CH_W-1:0]       ch_mask,
    output logic [CH_W-1:0]          channel_id,
    output logic [TS_W-1:0]          timestamp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     ts_wrap
);

    localparam int W = CH_W + TS_W;

    logic [CH_W-1:0] in_ch;
    logic            in_pass;
    logic            accept;
    logic            out_load;
    logic            deliver;
    logic            wr_en;
    logic            rd_en;
    logic            drop;
    logic [W-1:0]    fifo_dout;
    logic [TS_W-1:0] last_ts;
    logic            first;

    assign in_ch    = aer_data[W-1:TS_W];
    assign in_pass  = ch_mask[in_ch];
    assign accept   = aer_valid && aer_ready;
    assign out_load = !out_valid || out_ready;
    assign deliver  = out_valid && out_ready;

    assign rd_en = out_load && !fifo_empty;
    assign wr_en = accept && in_pass && (!fifo_full || rd_en);
    assign drop  = accept && in_pass && fifo_full && !rd_en;

    assign aer_ready = rst_n && ((DROP_ON_FULL != 0) || !fifo_full);

    assign ts_wrap = deliver && !first && (timestamp < last_ts);

    aer_sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (aer_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            channel_id <= '0;
            timestamp  <= '0;
        end else if (out_load) begin
            out_valid <= !fifo_empty;
            if (!fifo_empty) begin
                {channel_id, timestamp} <= fifo_dout;
            end
        end
    end

    // Reference for rollover detection is the last delivered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ts <= '0;
            first   <= 1'b1;
        end else if (deliver) begin
            last_ts <= timestamp;
            first   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_aer_ingress_pipe.sv
// Directed bench: backpressure instance (a_*) and drop-mode instance (b_*).
module tb_aer_ingress_pipe;
    import aer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [23:0] a_data, b_data;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [15:0] a_mask, b_mask;
    logic [3:0]  a_ch, b_ch;
    logic [19:0] a_ts, b_ts;
    logic        a_ov, b_ov;
    logic        a_or, b_or;
    logic        a_full, b_full;
    logic        a_empty, b_empty;
    logic [4:0]  a_level, b_level;
    logic [15:0] a_drop, b_drop;
    logic        a_wrap, b_wrap;

    int errs = 0;
    int checks = 0;

    aer_ingress_pipe #(.DEPTH(16), .DROP_ON_FULL(0)) u_bp (
        .clk(clk), .rst_n(rst_n),
        .aer_data(a_data), .aer_valid(a_valid), .aer_ready(a_ready),
        .ch_mask(a_mask),
        .channel_id(a_ch), .timestamp(a_ts),
        .out_valid(a_ov), .out_ready(a_or),
        .fifo_full(a_full), .fifo_empty(a_empty), .fifo_level(a_level),
        .drop_cnt(a_drop), .ts_wrap(a_wrap)
    );

    aer_ingress_pipe #(.DEPTH(16), .DROP_ON_FULL(1)) u_dr (
        .clk(clk), .rst_n(rst_n),
        .aer_data(b_data), .aer_valid(b_valid), .aer_ready(b_ready),
        .ch_mask(b_mask),
        .channel_id(b_ch), .timestamp(b_ts),
        .out_valid(b_ov), .out_ready(b_or),
        .fifo_full(b_full), .fifo_empty(b_empty), .fifo_level(b_level),
        .drop_cnt(b_drop), .ts_wrap(b_wrap)
    );

    function automatic logic [23:0] mk(input int ch, input int ts);
        logic [31:0] c;
        logic [31:0] t;
        c = ch;
        t = ts;
        return aer_pack(c[3:0], t[19:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_data = '0; a_valid = 0; a_mask = 16'hFFFF; a_or = 0;
        b_data = '0; b_valid = 0; b_mask = 16'hFFFF; b_or = 0;
        #12;
        checks++;
        if ({a_ready, a_ov, a_ch, a_ts} !== 26'd0) begin
            errs++;
            $display("FAIL reset_out_a: got %h want 0", {a_ready, a_ov, a_ch, a_ts});
        end
        checks++;
        if ({a_empty, a_full, a_level, a_drop, a_wrap} !== {1'b1, 23'd0}) begin
            errs++;
            $display("FAIL reset_stat_a: got %h want %h",
                     {a_empty, a_full, a_level, a_drop, a_wrap}, {1'b1, 23'd0});
        end
        checks++;
        if ({b_ready, b_ov, b_empty, b_full, b_level, b_drop, b_wrap} !== {3'b001, 23'd0}) begin
            errs++;
            $display("FAIL reset_b: got %h want %h",
                     {b_ready, b_ov, b_empty, b_full, b_level, b_drop, b_wrap}, {3'b001, 23'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        a_or = 1;
        a_data = mk(3, 'h10);
        a_valid = 1;
        tick();
        a_valid = 0;
        checks++;
        if ({a_ov, a_level} !== {1'b0, 5'd1}) begin
            errs++;
            $display("FAIL single_lat1: ov/level got %b/%0d want 0/1", a_ov, a_level);
        end
        tick();
        checks++;
        if ({a_ov, a_ch, a_ts} !== {1'b1, 4'h3, 20'h00010}) begin
            errs++;
            $display("FAIL single_out: got %b %h %h want 1 3 00010", a_ov, a_ch, a_ts);
        end
        tick();
        checks++;
        if (a_ov !== 1'b0) begin
            errs++;
            $display("FAIL single_once: out_valid got %b want 0", a_ov);
        end
    endtask

    task automatic test_fill_backpressure();
        int n;
        a_or = 0;
        for (int i = 0; i < 17; i++) begin
            a_data = mk(i, 100 + i);
            a_valid = 1;
            tick();
        end
        a_valid = 0;
        checks++;
        if ({a_level, a_full, a_ready, a_ov, a_ts} !== {5'd16, 3'b101, 20'd100}) begin
            errs++;
            $display("FAIL fill_state: lvl=%0d full=%b rdy=%b ov=%b ts=%0d want 16 1 0 1 100",
                     a_level, a_full, a_ready, a_ov, a_ts);
        end
        a_data = mk(15, 999);
        a_valid = 1;
        tick();
        a_valid = 0;
        checks++;
        if (a_level !== 5'd16) begin
            errs++;
            $display("FAIL fill_blocked: level got %0d want 16", a_level);
        end
        a_or = 1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (a_ov) begin
                checks++;
                if ({a_ch, a_ts} !== mk(n, 100 + n)) begin
                    errs++;
                    $display("FAIL fill_order[%0d]: got %h want %h", n, {a_ch, a_ts}, mk(n, 100 + n));
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 17) begin
            errs++;
            $display("FAIL fill_count: got %0d want 17", n);
        end
    endtask

    task automatic test_mask();
        int n;
        int chs[3] = '{2, 5, 2};
        b_mask = 16'hFFFB;
        b_or = 1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (b_ov) begin
                n++;
                checks++;
                if ({b_ch, b_ts} !== mk(5, 2)) begin
                    errs++;
                    $display("FAIL mask_word: got %h want %h", {b_ch, b_ts}, mk(5, 2));
                end
            end
            if (c < 3) begin
                b_data = mk(chs[c], c + 1);
                b_valid = 1;
            end else begin
                b_valid = 0;
            end
            tick();
        end
        checks++;
        if (n != 1) begin
            errs++;
            $display("FAIL mask_count: got %0d want 1", n);
        end
        checks++;
        if (b_drop !== 16'd0) begin
            errs++;
            $display("FAIL mask_drop: got %0d want 0", b_drop);
        end
        b_mask = 16'hFFFF;
    endtask

    task automatic test_wrap();
        int pulses;
        int tss[4] = '{'hFFFFE, 'hFFFFF, 'h00001, 'h00001};
        a_or = 1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (a_wrap) begin
                pulses++;
                checks++;
                if ({a_ov, a_ts} !== {1'b1, 20'h00001}) begin
                    errs++;
                    $display("FAIL wrap_at: ov/ts got %b/%h want 1/00001", a_ov, a_ts);
                end
            end
            if (c < 4) begin
                a_data = mk(1, tss[c]);
                a_valid = 1;
            end else begin
                a_valid = 0;
            end
            tick();
        end
        checks++;
        if (pulses != 1) begin
            errs++;
            $display("FAIL wrap_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_drop();
        int n;
        b_or = 0;
        for (int i = 0; i < 20; i++) begin
            b_data = mk(i, 200 + i);
            b_valid = 1;
            if (i == 19) begin
                checks++;
                if (b_ready !== 1'b1) begin
                    errs++;
                    $display("FAIL drop_ready: got %b want 1", b_ready);
                end
            end
            tick();
        end
        b_valid = 0;
        checks++;
        if ({b_drop, b_level, b_full} !== {16'd3, 5'd16, 1'b1}) begin
            errs++;
            $display("FAIL drop_state: cnt=%0d lvl=%0d full=%b want 3 16 1",
                     b_drop, b_level, b_full);
        end
        b_or = 1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (b_ov) begin
                checks++;
                if ({b_ch, b_ts} !== mk(n, 200 + n)) begin
                    errs++;
                    $display("FAIL drop_order[%0d]: got %h want %h", n, {b_ch, b_ts}, mk(n, 200 + n));
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 17) begin
            errs++;
            $display("FAIL drop_deliv: got %0d want 17", n);
        end
    endtask

    task automatic test_reset_mid();
        a_or = 0;
        for (int i = 0; i < 5; i++) begin
            a_data = mk(i, 300 + i);
            a_valid = 1;
            tick();
        end
        a_valid = 0;
        checks++;
        if ({a_ov, a_level} !== {1'b1, 5'd4}) begin
            errs++;
            $display("FAIL mid_pre: ov/level got %b/%0d want 1/4", a_ov, a_level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ov, a_level, a_empty, a_ready} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL mid_rst: ov=%b lvl=%0d empty=%b rdy=%b want 0 0 1 0",
                     a_ov, a_level, a_empty, a_ready);
        end
        checks++;
        if (b_drop !== 16'd0) begin
            errs++;
            $display("FAIL mid_dropcnt: got %0d want 0", b_drop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_or = 1;
        a_data = mk(9, 0);
        a_valid = 1;
        tick();
        a_valid = 0;
        checks++;
        if (a_ov !== 1'b0) begin
            errs++;
            $display("FAIL mid_lat1: out_valid got %b want 0", a_ov);
        end
        tick();
        checks++;
        if ({a_ov, a_ch, a_ts, a_wrap} !== {1'b1, 4'h9, 20'h0, 1'b0}) begin
            errs++;
            $display("FAIL mid_out: got %b %h %h wrap=%b want 1 9 00000 0",
                     a_ov, a_ch, a_ts, a_wrap);
        end
        tick();
        checks++;
        if (a_ov !== 1'b0) begin
            errs++;
            $display("FAIL mid_once: out_valid got %b want 0", a_ov);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_backpressure();
        test_mask();
        test_wrap();
        test_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/aer_ingress_pipe.md
AER_INGRESS_PIPE -- requirements
Module: aer_ingress_pipe

Interface
REQ-001 Parameter CH_W, default 4, channel-ID field width in bits.
REQ-002 Parameter TS_W, default 20, timestamp field width in bits.
REQ-003 Parameter DEPTH, default 16, FIFO depth in words, a power of two and at least 2.
REQ-004 Parameter DROP_ON_FULL, default 0, overflow mode: 0 = backpressure, 1 = drop and count.
REQ-005 Parameter CNT_W, default 16, drop-counter width.
REQ-006 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  input  1  single clock; all logic on the rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 aer_data  input  CH_W+TS_W  AER word: {channel[CH_W-1:0], timestamp[TS_W-1:0]}, channel in the MSBs.
REQ-010 aer_valid  input  1  producer word valid.
REQ-011 aer_ready  output  1  module accepts a word this cycle.
REQ-012 ch_mask  input  2**CH_W  per-channel enable; bit i = 1 passes channel i.
REQ-013 channel_id  output  CH_W  head-word channel.
REQ-014 timestamp  output  TS_W  head-word timestamp.
REQ-015 out_valid  output  1  channel_id and timestamp are valid.
REQ-016 out_ready  input  1  consumer accepts the head word.
REQ-017 fifo_full, fifo_empty  output  1 each  storage status, excluding the output register.
REQ-018 fifo_level  output  $clog2(DEPTH)+1  words held in the FIFO.
REQ-019 drop_cnt  output  CNT_W  saturating count of dropped words.
REQ-020 ts_wrap  output  1  one-cycle pulse, timestamp rollover detected at the output.

Function
REQ-021 Acceptance SHALL be aer_valid && aer_ready; the word is written only if ch_mask[channel] = 1, otherwise it is discarded silently and not counted.
REQ-022 With DROP_ON_FULL = 0, aer_ready SHALL equal !fifo_full.
REQ-023 With DROP_ON_FULL = 1, aer_ready SHALL be 1 except during reset.
  - A valid, unmasked word arriving while full is dropped.
  - drop_cnt increments by 1 and saturates at 2**CNT_W-1.
REQ-024 The output stage SHALL be a single register loaded from the FIFO head whenever it is empty, or when it is full and out_valid && out_ready.
REQ-025 Latency SHALL be 2 cycles minimum: a word accepted at edge N is in the FIFO after edge N and on out_valid after edge N+1; there is no combinational bypass.
REQ-026 Simultaneous FIFO write and read SHALL both occur and leave fifo_level unchanged, including when fifo_full = 1 (read frees a slot only in the next cycle for aer_ready).
REQ-027 channel_id, timestamp and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-028 FIFO read and write pointers SHALL wrap modulo DEPTH; fifo_full = (fifo_level == DEPTH) and fifo_empty = (fifo_level == 0).
REQ-029 ts_wrap SHALL pulse for one cycle when a word leaves the output register with a timestamp strictly less than the previously delivered timestamp.
  - The first word after reset never pulses.
  - Equal timestamps do not pulse.
REQ-030 ch_mask changes SHALL affect only words accepted after the change; stored words are never filtered.

Reset
REQ-031 While rst_n = 0, the block SHALL hold these values:
  - aer_ready = 0, out_valid = 0, channel_id = 0, timestamp = 0.
  - fifo_empty = 1, fifo_full = 0, fifo_level = 0.
  - drop_cnt = 0, ts_wrap = 0, pointers = 0.
  - The "first word" flag is set.
REQ-032 Reset asserted mid-transfer SHALL discard all stored words immediately; operation resumes on the first edge after deassertion.

Structure
REQ-033 Package aer_pkg SHALL hold AER_CH_W = 4, AER_TS_W = 20 and typedef aer_word_t (packed struct {ch, ts}).
REQ-034 Storage SHALL be a sub-module aer_sync_fifo (parametrised WIDTH, DEPTH; ports wr_en, rd_en, din, dout, full, empty, level). Masking, drop logic, the output register and wrap detection live in the top level.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
  - Single word: aer_data = {4'h3, 20'h00010}, out_ready = 1 -> out_valid two cycles later with channel_id = 3, timestamp = 0x10 for one cycle.
  - Fill, backpressure (DROP_ON_FULL = 0, DEPTH = 16, out_ready = 0): 17 words -> 16 in the FIFO plus 1 in the output register; fifo_full = 1, aer_ready = 0; all 17 delivered in order after out_ready = 1.
  - Drop mode (DROP_ON_FULL = 1, out_ready = 0): 20 words -> drop_cnt = 3; the first 17 words are delivered in order.
  - Mask: ch_mask = 16'hFFFB, words on channels 2, 5, 2 -> only channel 5 delivered; drop_cnt = 0.
  - Wrap: timestamps 0xFFFFE, 0xFFFFF, 0x00001 -> ts_wrap pulses once, coinciding with delivery of 0x00001.
  - Reset with 5 words stored -> out_valid = 0 and fifo_level = 0 immediately; the next word is delivered with 2-cycle latency.
